// File: rtl/demux_stream_pkg.sv
// demux_stream_pkg: shared defaults and counter width for the stream demultiplexer.
package demux_stream_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int N_OUT_DEF = 4;
    localparam int CNT_W     = 8;
endpackage

// File: rtl/stream_slice.sv
// stream_slice: one-entry register slice with load/pop and a wrapping delivered-word counter.
module stream_slice
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;

    // load wins over pop so a full channel can stream one word per cycle
    always_comb begin
        pop     = valid_q && ready_i;
        valid_d = load_i ? 1'b1 : (pop ? 1'b0 : valid_q);
        data_d  = load_i ? data_i : data_q;
        cnt_d   = pop ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/demux_stream.sv
// demux_stream: routes an upstream valid/ready stream to one of N_OUT registered channels.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid,
    output logic                   up_ready,
    input  logic [WIDTH-1:0]       up_data,
    input  logic [SEL_W-1:0]       up_sel,
    output logic [N_OUT-1:0]       dn_valid,
    input  logic [N_OUT-1:0]       dn_ready,
    output logic [N_OUT*WIDTH-1:0] dn_data,
    output logic [N_OUT*CNT_W-1:0] dn_count,
    output logic [CNT_W-1:0]       drop_count
);
    localparam int N_EXT = 1 << SEL_W;

    logic [N_EXT-1:0] v_ext, r_ext;
    logic [N_OUT-1:0] load;
    logic             sel_ok, fire;
    logic [CNT_W-1:0] drop_q, drop_d;

    // padded copies keep the select mux in range for non-power-of-2 N_OUT
    always_comb begin
        v_ext              = '0;
        r_ext              = '0;
        v_ext[N_OUT-1:0]   = dn_valid;
        r_ext[N_OUT-1:0]   = dn_ready;
        sel_ok             = 32'(up_sel) < N_OUT;
        up_ready           = rst_n && (sel_ok ? (!v_ext[up_sel] || r_ext[up_sel]) : 1'b1);
        fire               = up_valid && up_ready && sel_ok;
        for (int i = 0; i < N_OUT; i++) load[i] = fire && (32'(up_sel) == i);
        drop_d             = (up_valid && !sel_ok && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_count = drop_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_ch
        stream_slice #(.WIDTH(WIDTH)) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load[k]),
            .data_i  (up_data),
            .ready_i (dn_ready[k]),
            .valid_o (dn_valid[k]),
            .data_o  (dn_data[k*WIDTH +: WIDTH]),
            .count_o (dn_count[k*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_demux_stream.sv
// tb_demux_stream: directed checks of routing, backpressure, counters, drops and async reset.
module tb_demux_stream;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uv = 1'b0, uv3 = 1'b0;
    logic        ur, ur3;
    logic [7:0]  ud = '0, ud3 = '0;
    logic [1:0]  us = '0, us3 = '0;
    logic [3:0]  dv, dr = '0;
    logic [2:0]  dv3, dr3 = '0;
    logic [31:0] dd, dc;
    logic [23:0] dd3, dc3;
    logic [7:0]  drop, drop3;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    demux_stream dut (
        .clk(clk), .rst_n(rst_n), .up_valid(uv), .up_ready(ur), .up_data(ud), .up_sel(us),
        .dn_valid(dv), .dn_ready(dr), .dn_data(dd), .dn_count(dc), .drop_count(drop)
    );

    demux_stream #(.N_OUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .up_valid(uv3), .up_ready(ur3), .up_data(ud3), .up_sel(us3),
        .dn_valid(dv3), .dn_ready(dr3), .dn_data(dd3), .dn_count(dc3), .drop_count(drop3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(dv), 32'h0);
        chk("rst_count", dc, 32'h0);
        chk("rst_ready", 32'(ur), 32'h0);
        #7 rst_n = 1'b1;
        // single word to channel 2, stalled
        uv = 1'b1; us = 2'd2; ud = 8'hA5; dr = 4'b0000;
        #1 chk("first_ready", 32'(ur), 32'h1);
        step();
        uv = 1'b0;
        chk("a5_valid", 32'(dv), 32'h4);
        chk("a5_data", 32'(dd[23:16]), 32'hA5);
        chk("a5_full_ready", 32'(ur), 32'h0);
        dr = 4'b0100;
        step();
        chk("a5_drained", 32'(dv), 32'h0);
        chk("a5_count", 32'(dc[23:16]), 32'h1);
        // back-to-back on channel 1 while full
        uv = 1'b1; us = 2'd1; ud = 8'h33; dr = 4'b0000;
        step();
        chk("ch1_full", 32'(dv), 32'h2);
        dr = 4'b0010; ud = 8'h11;
        #1 chk("b2b_ready0", 32'(ur), 32'h1);
        step();
        chk("b2b_11", 32'(dd[15:8]), 32'h11);
        chk("b2b_ready1", 32'(ur), 32'h1);
        ud = 8'h22;
        step();
        chk("b2b_22", 32'(dd[15:8]), 32'h22);
        chk("b2b_count", 32'(dc[15:8]), 32'h2);
        uv = 1'b0;
        step();
        chk("b2b_empty", 32'(dv), 32'h0);
        chk("b2b_count_end", 32'(dc[15:8]), 32'h3);
        // stalled channel 0 does not block channel 3
        dr = 4'b0000; uv = 1'b1; us = 2'd0; ud = 8'h3C;
        step();
        us = 2'd3; ud = 8'h77;
        #1 chk("indep_ready", 32'(ur), 32'h1);
        step();
        uv = 1'b0; ud = 8'hEE; us = 2'd0;
        chk("indep_valid", 32'(dv), 32'h9);
        chk("indep_ch0", 32'(dd[7:0]), 32'h3C);
        chk("indep_ch3", 32'(dd[31:24]), 32'h77);
        step();
        chk("stall_stable", 32'(dd[7:0]), 32'h3C);
        chk("idle_no_load", 32'(dv), 32'h9);
        dr = 4'hF;
        step();
        chk("drain_all", 32'(dv), 32'h0);
        chk("counts", dc, 32'h01010301);
        // fill all four then reset between edges
        dr = 4'h0; uv = 1'b1;
        for (int i = 0; i < 4; i++) begin
            us = 2'(i); ud = 8'(8'h40 + i);
            step();
        end
        uv = 1'b0;
        chk("all_full", 32'(dv), 32'hF);
        chk("all_data", dd, 32'h43424140);
        #1 rst_n = 1'b0; uv = 1'b1; us = 2'd0;
        #1;
        chk("mid_rst_valid", 32'(dv), 32'h0);
        chk("mid_rst_data", dd, 32'h0);
        chk("mid_rst_count", dc, 32'h0);
        chk("mid_rst_ready", 32'(ur), 32'h0);
        #1 rst_n = 1'b1; uv = 1'b0;
        // 256 words to channel 0: counter wraps
        dr = 4'hF; uv = 1'b1; us = 2'd0;
        for (int i = 0; i < 256; i++) begin
            ud = 8'(i);
            step();
        end
        uv = 1'b0;
        chk("wrap_ff", 32'(dc[7:0]), 32'hFF);
        chk("wrap_last", 32'(dd[7:0]), 32'hFF);
        step();
        chk("wrap_zero", dc, 32'h0);
        chk("wrap_empty", 32'(dv), 32'h0);
        chk("drop4", 32'(drop), 32'h0);
        // illegal select on the 3-channel instance
        uv3 = 1'b1; us3 = 2'd3; ud3 = 8'h99;
        #1 chk("ill_ready", 32'(ur3), 32'h1);
        step();
        step();
        uv3 = 1'b0;
        chk("ill_valid", 32'(dv3), 32'h0);
        chk("ill_drop2", 32'(drop3), 32'h2);
        step();
        chk("ill_idle", 32'(drop3), 32'h2);
        uv3 = 1'b1;
        for (int i = 0; i < 260; i++) step();
        uv3 = 1'b0;
        chk("ill_sat", 32'(drop3), 32'hFF);
        chk("ill_sat_valid", 32'(dv3), 32'h0);
        uv3 = 1'b1; us3 = 2'd2; ud3 = 8'h5A;
        step();
        uv3 = 1'b0;
        chk("n3_ch2", 32'(dv3), 32'h4);
        chk("n3_data", 32'(dd3[23:16]), 32'h5A);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
